// File: rtl/tcdm_pkg.sv
// Shared TCDM constants: data/byte-enable widths and the active-low
// write-enable encoding used on the initiator ports.
package tcdm_pkg;

  localparam int   TCDM_DATA_WIDTH = 32;
  localparam int   TCDM_BE_WIDTH   = 4;
  localparam logic TCDM_WRITE      = 1'b0;
  localparam logic TCDM_READ       = 1'b1;

endpackage

// File: rtl/tcdm_rr_arb.sv
// Round-robin arbiter for the TCDM bank: picks the first requester at or
// after the pointer, suppresses the grant under stall, and advances the pointer.
module tcdm_rr_arb #(
  parameter  int NB_PORTS = 4,
  localparam int IDX_W    = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NB_PORTS-1:0] req_i,
  input  logic                stall_i,
  output logic [NB_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]    win_o,
  output logic                any_gnt_o
);

  logic [IDX_W-1:0] rr_q, rr_d;
  logic             found;
  logic [IDX_W:0]   cand;

  // Scan from the pointer upward with wrap; the first requester wins.
  always_comb begin
    found = 1'b0;
    win_o = '0;
    cand  = '0;
    for (int i = 0; i < NB_PORTS; i++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NB_PORTS)) cand = cand - (IDX_W+1)'(NB_PORTS);
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win_o = cand[IDX_W-1:0];
      end
    end
  end

  assign any_gnt_o = found & ~stall_i;

  generate
    for (genvar gi = 0; gi < NB_PORTS; gi++) begin : g_gnt
      assign gnt_o[gi] = any_gnt_o && (win_o == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    rr_d = rr_q;
    if (any_gnt_o) begin
      if (win_o == IDX_W'(NB_PORTS - 1)) rr_d = '0;
      else                               rr_d = win_o + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/tcdm_bank_responder.sv
// Single-bank TCDM responder: round-robin grant, byte-enabled writes and a
// registered one-cycle response carrying read data or the post-write word.
module tcdm_bank_responder
  import tcdm_pkg::*;
#(
  parameter int NB_PORTS        = 4,
  parameter int ADDR_WIDTH      = 10,
  parameter int TRANS_SID_WIDTH = 1
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic                                             stall_i,
  input  logic [NB_PORTS-1:0]                              tcdm_req_i,
  input  logic [NB_PORTS-1:0][31:0]                        tcdm_add_i,
  input  logic [NB_PORTS-1:0]                              tcdm_we_i,
  input  logic [NB_PORTS-1:0][TCDM_DATA_WIDTH-1:0]         tcdm_wdata_i,
  input  logic [NB_PORTS-1:0][TCDM_BE_WIDTH-1:0]           tcdm_be_i,
  input  logic [NB_PORTS-1:0][TRANS_SID_WIDTH-1:0]         tcdm_sid_i,
  output logic [NB_PORTS-1:0]                              tcdm_gnt_o,
  output logic [NB_PORTS-1:0]                              tcdm_r_valid_o,
  output logic [NB_PORTS-1:0][TCDM_DATA_WIDTH-1:0]         tcdm_r_rdata_o,
  output logic [TRANS_SID_WIDTH-1:0]                       tcdm_r_sid_o
);

  localparam int IDX_W = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;

  logic [IDX_W-1:0]           win;
  logic                       any_gnt;
  logic [ADDR_WIDTH-1:0]      idx;
  logic                       is_write;
  logic [TCDM_DATA_WIDTH-1:0] rd_word, wr_word;
  logic                       unused_add;

  logic [TCDM_DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  logic [NB_PORTS-1:0]        valid_q, valid_d;
  logic [TCDM_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [TRANS_SID_WIDTH-1:0] sid_q, sid_d;

  tcdm_rr_arb #(.NB_PORTS(NB_PORTS)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (tcdm_req_i),
    .stall_i   (stall_i),
    .gnt_o     (tcdm_gnt_o),
    .win_o     (win),
    .any_gnt_o (any_gnt)
  );

  // Byte offset and bits above the bank size are ignored, so addresses wrap.
  assign idx        = tcdm_add_i[win][ADDR_WIDTH+1:2];
  assign unused_add = ^tcdm_add_i;
  assign rd_word    = mem_q[idx];
  assign is_write   = (tcdm_we_i[win] == TCDM_WRITE);

  generate
    for (genvar gi = 0; gi < TCDM_BE_WIDTH; gi++) begin : g_be
      assign wr_word[8*gi +: 8] = tcdm_be_i[win][gi] ? tcdm_wdata_i[win][8*gi +: 8]
                                                     : rd_word[8*gi +: 8];
    end
  endgenerate

  // Contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (any_gnt && is_write) mem_q[idx] <= wr_word;
  end

  always_comb begin
    valid_d = tcdm_gnt_o;
    rdata_d = rdata_q;
    sid_d   = sid_q;
    if (any_gnt) begin
      rdata_d = is_write ? wr_word : rd_word;
      sid_d   = tcdm_sid_i[win];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      rdata_q <= '0;
      sid_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      sid_q   <= sid_d;
    end
  end

  assign tcdm_r_valid_o = valid_q;
  assign tcdm_r_sid_o   = sid_q;

  generate
    for (genvar gi = 0; gi < NB_PORTS; gi++) begin : g_rdata
      assign tcdm_r_rdata_o[gi] = rdata_q;
    end
  endgenerate

endmodule
